// File: rtl/timer_sequencer_pkg.sv
// timer_sequencer_pkg: shared state/direction encodings and default timing constants.
package timer_sequencer_pkg;
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_ALARM = 2'd3
    } state_t;

    localparam logic DIR_UP   = 1'b0;
    localparam logic DIR_DOWN = 1'b1;

    localparam logic [6:0] ALARM_SECS_DEF = 7'd60;
    localparam logic [2:0] REP_DLY_DEF    = 3'd2;
endpackage

// File: rtl/timer_sequencer_if.sv
// timer_sequencer_if: button/tick inputs and datapath commands of the timer sequencer.
interface timer_sequencer_if;
    import timer_sequencer_pkg::*;
    logic   START_P, STOP_P, M_P, S_P, M_HELD, S_HELD, UP_DOWN_P;
    logic   ONE_SEC_PULSE, HALF_SEC_PULSE, TIME_ZERO, TIME_MAX;
    state_t STATE;
    logic   INC_MIN, INC_SEC, CLR_TIME, CNT_TICK, CNT_DIR, ARM_EN, BLINK;
    modport master (
        output START_P, STOP_P, M_P, S_P, M_HELD, S_HELD, UP_DOWN_P,
               ONE_SEC_PULSE, HALF_SEC_PULSE, TIME_ZERO, TIME_MAX,
        input  STATE, INC_MIN, INC_SEC, CLR_TIME, CNT_TICK, CNT_DIR, ARM_EN, BLINK
    );
    modport slave (
        input  START_P, STOP_P, M_P, S_P, M_HELD, S_HELD, UP_DOWN_P,
               ONE_SEC_PULSE, HALF_SEC_PULSE, TIME_ZERO, TIME_MAX,
        output STATE, INC_MIN, INC_SEC, CLR_TIME, CNT_TICK, CNT_DIR, ARM_EN, BLINK
    );
endinterface

// File: rtl/timer_sequencer_key_repeat.sv
// key_repeat: single-press increment plus hold-to-repeat after REP_DLY half-second ticks.
module key_repeat
    import timer_sequencer_pkg::*;
#(
    parameter logic [2:0] REP_DLY = REP_DLY_DEF
) (
    input  logic CLK,
    input  logic RES,
    input  logic P,
    input  logic HELD,
    input  logic HALF_SEC_PULSE,
    input  logic EN,
    output logic INC
);
    logic [2:0] cnt_q, cnt_d;
    logic       inc_q, inc_d;

    always_comb begin
        cnt_d = !HELD ? 3'd0 : (HALF_SEC_PULSE && cnt_q < REP_DLY) ? cnt_q + 3'd1 : cnt_q;
        inc_d = EN && (P || (HELD && HALF_SEC_PULSE && cnt_q >= REP_DLY));
    end

    always_ff @(posedge CLK) begin
        if (RES) begin
            cnt_q <= 3'd0;
            inc_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            inc_q <= inc_d;
        end
    end

    assign INC = inc_q;
endmodule

// File: rtl/timer_sequencer.sv
// timer_sequencer: IDLE/RUN/PAUSE/ALARM mode controller issuing one-cycle datapath commands.
module timer_sequencer
    import timer_sequencer_pkg::*;
#(
    parameter logic [6:0] ALARM_SECS = ALARM_SECS_DEF,
    parameter logic [2:0] REP_DLY    = REP_DLY_DEF
) (
    input  logic               CLK,
    input  logic               RES,
    timer_sequencer_if.slave   bus
);
    state_t     state_q;
    logic       clr_q, tick_q, dir_q, arm_q, blink_q;
    logic [6:0] acnt_q;
    logic       start_ok, key_en, alarm_done;

    // A down-count start from 00:00 would alarm immediately, so it is refused.
    assign start_ok   = !(dir_q == DIR_DOWN && bus.TIME_ZERO);
    assign key_en     = state_q == ST_IDLE && !bus.STOP_P && !(bus.START_P && start_ok);
    assign alarm_done = bus.ONE_SEC_PULSE && (acnt_q + 7'd1 >= ALARM_SECS);

    always_ff @(posedge CLK) begin
        if (RES) begin
            state_q <= ST_IDLE;
            clr_q   <= 1'b0;
            tick_q  <= 1'b0;
            dir_q   <= DIR_DOWN;
            arm_q   <= 1'b0;
            blink_q <= 1'b0;
            acnt_q  <= 7'd0;
        end else begin
            clr_q  <= 1'b0;
            tick_q <= 1'b0;
            case (state_q)
                ST_IDLE:
                    if (bus.STOP_P) clr_q <= 1'b1;
                    else if (bus.START_P && start_ok) state_q <= ST_RUN;
                    else if (bus.UP_DOWN_P) dir_q <= ~dir_q;
                ST_RUN:
                    if (bus.STOP_P) state_q <= ST_PAUSE;
                    else if (dir_q == DIR_DOWN ? bus.TIME_ZERO : bus.ONE_SEC_PULSE && bus.TIME_MAX) begin
                        state_q <= ST_ALARM;
                        arm_q   <= 1'b1;
                    end else tick_q <= bus.ONE_SEC_PULSE;
                ST_PAUSE:
                    if (bus.STOP_P) begin
                        state_q <= ST_IDLE;
                        clr_q   <= 1'b1;
                        blink_q <= 1'b0;
                    end else if (bus.START_P) begin
                        state_q <= ST_RUN;
                        blink_q <= 1'b0;
                    end else if (bus.HALF_SEC_PULSE) blink_q <= ~blink_q;
                ST_ALARM:
                    if (bus.STOP_P || bus.START_P || alarm_done) begin
                        state_q <= ST_IDLE;
                        arm_q   <= 1'b0;
                        blink_q <= 1'b0;
                        acnt_q  <= 7'd0;
                    end else begin
                        acnt_q  <= acnt_q + {6'd0, bus.ONE_SEC_PULSE};
                        blink_q <= blink_q ^ bus.HALF_SEC_PULSE;
                    end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    key_repeat #(.REP_DLY(REP_DLY)) u_min (
        .CLK(CLK), .RES(RES), .P(bus.M_P), .HELD(bus.M_HELD),
        .HALF_SEC_PULSE(bus.HALF_SEC_PULSE), .EN(key_en), .INC(bus.INC_MIN)
    );

    key_repeat #(.REP_DLY(REP_DLY)) u_sec (
        .CLK(CLK), .RES(RES), .P(bus.S_P), .HELD(bus.S_HELD),
        .HALF_SEC_PULSE(bus.HALF_SEC_PULSE), .EN(key_en), .INC(bus.INC_SEC)
    );

    assign bus.STATE    = state_q;
    assign bus.CLR_TIME = clr_q;
    assign bus.CNT_TICK = tick_q;
    assign bus.CNT_DIR  = dir_q;
    assign bus.ARM_EN   = arm_q;
    assign bus.BLINK    = blink_q;
endmodule

// File: doc/timer_sequencer.md
Name: timer_sequencer

Overview:
Central mode controller for the kitchen timer. It sits between the debounce/sync stage and the time-value datapath (set-time, up/down counter, alarm, display). It owns the IDLE/RUN/PAUSE/ALARM state machine and converts debounced button pulses and second/half-second ticks into one-cycle datapath commands. It also drives the alarm enable, the display blink signal and the minute/second button auto-repeat.

Parameters:
ALARM_SECS, 7'd60, number of ONE_SEC_PULSE ticks the alarm sounds before auto-return to IDLE
REP_DLY, 3'd2, HALF_SEC_PULSE ticks a key must be held before auto-repeat begins
ST_IDLE, 2'd0, state encoding
ST_RUN, 2'd1, state encoding
ST_PAUSE, 2'd2, state encoding
ST_ALARM, 2'd3, state encoding

Ports:
CLK  in  1  system clock
RES  in  1  synchronous active-high reset
START_P  in  1  debounced START, one-cycle pulse
STOP_P  in  1  debounced STOP, one-cycle pulse
M_P  in  1  debounced minute key, one-cycle pulse
S_P  in  1  debounced second key, one-cycle pulse
M_HELD  in  1  minute key held level
S_HELD  in  1  second key held level
UP_DOWN_P  in  1  debounced mode key, one-cycle pulse
ONE_SEC_PULSE  in  1  1 Hz strobe, one cycle
HALF_SEC_PULSE  in  1  2 Hz strobe, one cycle
TIME_ZERO  in  1  datapath value == 00:00
TIME_MAX  in  1  datapath value == 99:59
STATE  out  2  current state
INC_MIN  out  1  one-cycle increment-minute command
INC_SEC  out  1  one-cycle increment-second command
CLR_TIME  out  1  one-cycle clear-to-00:00 command
CNT_TICK  out  1  one-cycle count step command
CNT_DIR  out  1  1 = count down, 0 = count up
ARM_EN  out  1  alarm buzzer enable (level)
BLINK  out  1  display blank request, 1 = blank

Behaviour:
- One clock domain. RES is synchronous and active-high. All outputs are registered.
- Reset values: STATE = ST_IDLE, CNT_DIR = 1, BLINK = 0, all other outputs = 0. The repeat and alarm counters clear. Reset asserted mid-operation aborts immediately to these values.
- Latency: every command output asserts on the cycle after its causing input. Pulse commands last exactly one cycle.
- IDLE:
  - M_P -> INC_MIN; S_P -> INC_SEC. Both in the same cycle -> both assert.
  - Auto-repeat, per key:
    - Counter clears when HELD = 0.
    - Counter increments on HALF_SEC_PULSE while HELD = 1, saturating at REP_DLY.
    - Once saturated, each HALF_SEC_PULSE with HELD = 1 issues INC_x.
  - UP_DOWN_P toggles CNT_DIR. It is ignored in every other state.
  - STOP_P -> CLR_TIME.
  - START_P:
    - If CNT_DIR = 1 and TIME_ZERO = 1, ignore.
    - Else -> RUN.
- RUN:
  - ONE_SEC_PULSE -> CNT_TICK, except when the terminal condition already holds.
  - Down mode: TIME_ZERO = 1 -> ALARM next cycle, no further ticks.
  - Up mode: ONE_SEC_PULSE with TIME_MAX = 1 -> ALARM, no tick.
  - STOP_P -> PAUSE. It has priority over a same-cycle ONE_SEC_PULSE, so the tick is suppressed.
  - M/S keys and UP_DOWN_P are ignored.
- PAUSE:
  - BLINK toggles on each HALF_SEC_PULSE.
  - START_P -> RUN.
  - STOP_P -> IDLE with CLR_TIME.
  - BLINK forced 0 on exit.
- ALARM:
  - ARM_EN = 1 and BLINK toggles on HALF_SEC_PULSE.
  - Alarm counter counts ONE_SEC_PULSE. At ALARM_SECS -> IDLE.
  - START_P or STOP_P -> IDLE immediately, with no CLR_TIME.
  - On exit ARM_EN = 0, BLINK = 0, alarm counter cleared.
- Priority when several inputs arrive in one cycle: STOP_P > START_P > ONE_SEC_PULSE > keys.
- Counter widths: alarm counter 7 bits, repeat counters 3 bits. No wrap: all counters saturate or clear.

Decomposition:
- Shared package: state encodings (ST_*), CNT_DIR encodings (DIR_UP/DIR_DOWN), default ALARM_SECS and REP_DLY.
- One sub-module, key_repeat, instantiated twice (minute, second).
  - Inputs: CLK, RES, P, HELD, HALF_SEC_PULSE, EN.
  - Output: INC.
  - Encapsulates the repeat counter.

Test Plan:
- RES high 2 cycles -> STATE = 0, CNT_DIR = 1, all command outputs 0. Then M_P, S_P in one cycle -> INC_MIN = INC_SEC = 1 for exactly one cycle, one cycle later.
- M_HELD = 1 for 5 HALF_SEC_PULSEs with REP_DLY = 2 -> INC_MIN on pulses 3, 4, 5 only (3 increments).
- Down mode, TIME_ZERO = 0, START_P -> RUN. Then 3 ONE_SEC_PULSEs -> 3 CNT_TICKs. Raise TIME_ZERO -> STATE = ALARM next cycle, ARM_EN = 1, no further CNT_TICK.
- RUN, STOP_P coincident with ONE_SEC_PULSE -> PAUSE, no CNT_TICK. BLINK toggles on each HALF_SEC_PULSE. STOP_P -> IDLE, CLR_TIME = 1 once, BLINK = 0.
- ALARM with ALARM_SECS = 3 and no keys -> IDLE after 3rd ONE_SEC_PULSE, ARM_EN = 0. Repeat with STOP_P after 1 s -> immediate IDLE, no CLR_TIME.
- IDLE, UP_DOWN_P -> CNT_DIR = 0. START_P with TIME_ZERO = 1 -> RUN. TIME_MAX = 1 plus ONE_SEC_PULSE -> ALARM, no tick. RES asserted in ALARM -> IDLE, ARM_EN = 0, CNT_DIR = 1.
